// File: rtl/add_sub_pkg.sv
// rtl/add_sub_pkg.sv - shared op encoding, status flag type and flag helper for add_sub_pipe
package add_sub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Widest result the flag helper accepts; callers zero-extend narrower results.
    localparam int MAX_BIT = 256;
    localparam int IDX_W   = 8;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
        logic neg;
    } flags_t;

    // Returns {zero, neg}; r must be zero-extended above bit msb.
    function automatic logic [1:0] zero_neg(input logic [MAX_BIT-1:0] r,
                                            input logic [IDX_W-1:0]   msb);
        return {(r == '0), r[msb]};
    endfunction

endpackage

// File: rtl/add_sub_slice.sv
// rtl/add_sub_slice.sv - combinational W-bit ripple adder slice with carry-into-MSB tap
module add_sub_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         c_msb
);

    // Ripple the carry bit by bit, tapping the carry that enters the top bit.
    always_comb begin
        logic c;
        c     = cin;
        c_msb = cin;
        sum   = '0;
        for (int i = 0; i < W; i++) begin
            if (i == W - 1) begin
                c_msb = c;
            end
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/add_sub_pipe.sv
// rtl/add_sub_pipe.sv - pipelined add/subtract, one carry slice per register stage, global stall
module add_sub_pipe
    import add_sub_pkg::*;
#(
    parameter int BIT    = 32,
    parameter int STAGES = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [BIT-1:0] a_i,
    input  logic [BIT-1:0] b_i,
    input  logic           sub_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [BIT-1:0] result_o,
    output logic           cout_o,
    output logic           ovf_o,
    output logic           zero_o,
    output logic           neg_o
);

    localparam int W = BIT / STAGES;

    if ((STAGES < 1) || (BIT % STAGES != 0) || (BIT > MAX_BIT)) begin : g_bad_params
        $error("add_sub_pipe: BIT must be a multiple of STAGES and at most MAX_BIT");
    end

    // Whole pipe moves together: it advances whenever the output slot is empty or being drained.
    logic adv;
    assign adv         = !out_valid_o || out_ready_i;
    assign in_ready_o  = adv;
    assign out_valid_o = g_stage[STAGES-1].vld_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // REM: operand bits still to be added on entry to this stage; LOW: result bits done after it.
        localparam int REM = BIT - k * W;
        localparam int LOW = (k + 1) * W;

        logic           vin;
        logic [REM-1:0] a_cur;
        logic [REM-1:0] b_cur;
        logic           cin;
        logic [W-1:0]   sum;
        logic           cout;
        logic [LOW-1:0] r_next;
        logic           vld_q;
        logic [LOW-1:0] r_q;

        if (k == 0) begin : g_in
            // Subtraction is A + ~B + 1: invert B here, the +1 enters as the first carry-in.
            assign vin    = in_valid_i;
            assign a_cur  = a_i;
            assign b_cur  = b_i ^ {BIT{sub_i == OP_SUB}};
            assign cin    = (sub_i == OP_SUB);
            assign r_next = sum;
        end else begin : g_in
            assign vin    = g_stage[k-1].vld_q;
            assign a_cur  = g_stage[k-1].g_carry.a_q;
            assign b_cur  = g_stage[k-1].g_carry.b_q;
            assign cin    = g_stage[k-1].g_carry.c_q;
            assign r_next = {sum, g_stage[k-1].r_q};
        end

        // Valid bit and finished low result bits shift forward on every advance.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                vld_q <= 1'b0;
                r_q   <= '0;
            end else if (adv) begin
                vld_q <= vin;
                r_q   <= r_next;
            end
        end

        if (k < STAGES - 1) begin : g_carry
            logic               c_msb_unused;
            logic [REM-W-1:0]   a_q;
            logic [REM-W-1:0]   b_q;
            logic               c_q;

            add_sub_slice #(.W(W)) u_slice (
                .a     (a_cur[W-1:0]),
                .b     (b_cur[W-1:0]),
                .cin   (cin),
                .sum   (sum),
                .cout  (cout),
                .c_msb (c_msb_unused)
            );

            // Carry and unconsumed upper operand bits travel with the beat to the next slice.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    a_q <= '0;
                    b_q <= '0;
                    c_q <= 1'b0;
                end else if (adv) begin
                    a_q <= a_cur[REM-1:W];
                    b_q <= b_cur[REM-1:W];
                    c_q <= cout;
                end
            end
        end else begin : g_last
            logic   c_msb;
            flags_t flg_next;
            flags_t flg_q;

            add_sub_slice #(.W(W)) u_slice (
                .a     (a_cur[W-1:0]),
                .b     (b_cur[W-1:0]),
                .cin   (cin),
                .sum   (sum),
                .cout  (cout),
                .c_msb (c_msb)
            );

            // Status flags come from the final carries and the completed result.
            always_comb begin
                flg_next                      = '0;
                flg_next.cout                 = cout;
                flg_next.ovf                  = c_msb ^ cout;
                {flg_next.zero, flg_next.neg} = zero_neg(MAX_BIT'(r_next), IDX_W'(BIT - 1));
            end

            // Flags are registered alongside the result so they hold together under stall.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    flg_q <= '0;
                end else if (adv) begin
                    flg_q <= flg_next;
                end
            end
        end
    end

    assign result_o = g_stage[STAGES-1].r_q;
    assign cout_o   = g_stage[STAGES-1].g_last.flg_q.cout;
    assign ovf_o    = g_stage[STAGES-1].g_last.flg_q.ovf;
    assign zero_o   = g_stage[STAGES-1].g_last.flg_q.zero;
    assign neg_o    = g_stage[STAGES-1].g_last.flg_q.neg;

endmodule

// File: tb/tb_add_sub_pipe.sv
// tb/tb_add_sub_pipe.sv - self-checking bench for add_sub_pipe (BIT=32, STAGES=4)
module tb_add_sub_pipe;

    localparam int BIT    = 32;
    localparam int STAGES = 4;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [BIT-1:0]  a_i;
    logic [BIT-1:0]  b_i;
    logic            sub_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [BIT-1:0]  result_o;
    logic            cout_o;
    logic            ovf_o;
    logic            zero_o;
    logic            neg_o;

    always #5 clk = ~clk;

    add_sub_pipe #(.BIT(BIT), .STAGES(STAGES)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .sub_i       (sub_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .cout_o      (cout_o),
        .ovf_o       (ovf_o),
        .zero_o      (zero_o),
        .neg_o       (neg_o)
    );

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          cyc;
        bit          lat;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    exp_t        sb[$];
    exp_t        cur;
    int          checks    = 0;
    int          failures  = 0;
    int          cyc       = 0;
    bit          was_stall = 0;
    logic [35:0] held;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain wide arithmetic; flag order {cout, ovf, zero, neg}.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t        e;
        logic [32:0] full;
        logic [31:0] r;
        logic        v;
        if (s) full = {1'b0, a} + {1'b0, ~b} + 33'd1;
        else   full = {1'b0, a} + {1'b0, b};
        r = full[31:0];
        if (s) v = (a[31] != b[31]) && (r[31] != a[31]);
        else   v = (a[31] == b[31]) && (r[31] != a[31]);
        e.res = r;
        e.flg = {full[32], v, (r == 32'd0), r[31]};
        e.cyc = 0;
        e.lat = 0;
        return e;
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // One clock cycle: sample mid-cycle, score handshakes, then advance to the next negedge.
    task automatic step(output bit acc);
        exp_t e;
        acc = 0;
        #1;
        if (rst_i) begin
            sb.delete();
            was_stall = 0;
        end else begin
            check("in_ready_rule", in_ready_o, !out_valid_o || out_ready_i);
            if (was_stall) begin
                check("hold_valid", out_valid_o, 1'b1);
                check("hold_data", {result_o, cout_o, ovf_o, zero_o, neg_o}, held);
            end
            if (out_valid_o && out_ready_i) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("result", result_o, e.res);
                    check("flags", {cout_o, ovf_o, zero_o, neg_o}, e.flg);
                    if (e.lat) check("latency", cyc - e.cyc, STAGES);
                end
            end
            if (in_valid_i && in_ready_o) begin
                acc   = 1;
                e     = cur;
                e.cyc = cyc;
                sb.push_back(e);
            end
            was_stall = out_valid_o && !out_ready_i;
            held      = {result_o, cout_o, ovf_o, zero_o, neg_o};
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        bit acc;
        int n = 0;
        in_valid_i = 0;
        while (sb.size() > 0 && n < 30) begin
            step(acc);
            n++;
        end
        if (sb.size() > 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        bit   acc;
        int   sent;
        bit   pending;

        vecs = '{
            '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 4'b0000},
            '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b0101},
            '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 4'b0000},
            '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b1010},
            '{32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 4'b1010},
            '{32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 4'b0001},
            '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 4'b1100},
            '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 4'b0000},
            '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 4'b0001},
            '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 4'b1110}
        };

        rst_i       = 1;
        in_valid_i  = 0;
        out_ready_i = 1;
        a_i         = '0;
        b_i         = '0;
        sub_i       = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 0;
        #1;
        check("reset_out_valid", out_valid_o, 1'b0);
        check("reset_result", result_o, 32'd0);
        check("reset_flags", {cout_o, ovf_o, zero_o, neg_o}, 4'b0000);
        check("reset_in_ready", in_ready_o, 1'b1);

        // Directed vectors, one beat at a time, exact latency checked.
        for (int i = 0; i < 10; i++) begin
            a_i        = vecs[i].a;
            b_i        = vecs[i].b;
            sub_i      = vecs[i].sub;
            cur        = '{res: vecs[i].res, flg: vecs[i].flg, cyc: 0, lat: 1'b1};
            in_valid_i = 1;
            step(acc);
            check("directed_accept", acc, 1'b1);
            drain();
        end

        // Back-to-back beats with a 3-cycle consumer stall mid-stream.
        sent = 0;
        for (int c = 0; c < 40 && (sent < 6 || sb.size() > 0); c++) begin
            in_valid_i = (sent < 6);
            a_i        = 32'd100 * sent + 32'd1;
            b_i        = sent;
            sub_i      = sent[0];
            cur        = model(a_i, b_i, sub_i);
            out_ready_i = !(c >= 5 && c < 8);
            step(acc);
            if (acc) sent++;
        end
        out_ready_i = 1;
        check("bp_sent", sent, 6);
        check("bp_all_emitted", sb.size(), 0);
        drain();

        // Reset with three beats in flight: nothing stale may emerge afterwards.
        for (int i = 0; i < 3; i++) begin
            a_i        = $urandom;
            b_i        = $urandom;
            sub_i      = i[0];
            cur        = model(a_i, b_i, sub_i);
            in_valid_i = 1;
            step(acc);
        end
        in_valid_i = 0;
        rst_i      = 1;
        step(acc);
        rst_i = 0;
        #1;
        check("midreset_out_valid", out_valid_o, 1'b0);
        check("midreset_result", result_o, 32'd0);
        check("midreset_flags", {cout_o, ovf_o, zero_o, neg_o}, 4'b0000);
        repeat (6) step(acc);
        a_i        = 32'h1234_5678;
        b_i        = 32'h1111_1111;
        sub_i      = 0;
        cur        = '{res: 32'h2345_6789, flg: 4'b0000, cyc: 0, lat: 1'b1};
        in_valid_i = 1;
        step(acc);
        check("post_reset_accept", acc, 1'b1);
        drain();

        // Random traffic with random backpressure against the reference model.
        pending = 0;
        for (int c = 0; c < 400; c++) begin
            if (!pending) begin
                in_valid_i = ($urandom_range(0, 9) < 7);
                a_i        = rnd_op();
                b_i        = rnd_op();
                sub_i      = $urandom_range(0, 1);
                cur        = model(a_i, b_i, sub_i);
            end
            out_ready_i = ($urandom_range(0, 9) < 7);
            step(acc);
            pending = in_valid_i && !acc;
        end
        out_ready_i = 1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
